// File: rtl/chamber_ctrl.sv
// ---------------------------------------------------------------------------
// chamber_ctrl
//
// Sequences one airlock chamber through EVACUATED -> PRESSURIZING ->
// PRESSURIZED -> EVACUATING -> EVACUATED, with an integrated duration counter.
// Durations are programmable at the start of each transition. A transition
// can be reversed mid-way (if enabled). done/err pulses are provided for a
// supervising FSM.
//
// Parameters:
//   CNT_W         width of duration inputs, internal counter, remaining
//   PRESS_CYCLES  pressurize duration used when press_time == 0
//   EVAC_CYCLES   evacuate duration used when evac_time == 0
//   ALLOW_REVERSE 1: opposite request mid-transition reverses it
//                 0: opposite request mid-transition is rejected with err
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous reset, active-low
//   pressurize_req  in   level request to pressurize
//   evacuate_req    in   level request to evacuate
//   press_time      in   pressurize duration (0 selects PRESS_CYCLES)
//   evac_time       in   evacuate duration (0 selects EVAC_CYCLES)
//   pressurized     out  chamber is PRESSURIZED
//   evacuated       out  chamber is EVACUATED
//   busy            out  chamber is PRESSURIZING or EVACUATING
//   remaining       out  cycles left in current transition, 0 when stable
//   done            out  one-cycle pulse on entering a stable state
//   err             out  one-cycle pulse when a request is rejected
// ---------------------------------------------------------------------------
module chamber_ctrl #(
    parameter int CNT_W         = 8,
    parameter int PRESS_CYCLES  = 6,
    parameter int EVAC_CYCLES   = 6,
    parameter int ALLOW_REVERSE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pressurize_req,
    input  logic             evacuate_req,
    input  logic [CNT_W-1:0] press_time,
    input  logic [CNT_W-1:0] evac_time,
    output logic             pressurized,
    output logic             evacuated,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_EVACUATED    = 2'd0,
        ST_PRESSURIZING = 2'd1,
        ST_PRESSURIZED  = 2'd2,
        ST_EVACUATING   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRESS_DEF = CNT_W'(PRESS_CYCLES);
    localparam logic [CNT_W-1:0] EVAC_DEF  = CNT_W'(EVAC_CYCLES);
    localparam bit               REV_EN    = (ALLOW_REVERSE != 0);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_next;
    logic             done_q;
    logic             done_next;
    logic             err_q;
    logic             err_next;

    // Helper terms used by the next-state logic
    logic             both_req;
    logic             opposite_req;
    logic [CNT_W-1:0] press_len;
    logic [CNT_W-1:0] evac_len;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] reverse_len;
    state_t           target_state;
    state_t           reverse_state;

    assign both_req  = pressurize_req & evacuate_req;
    assign press_len = (press_time != CNT_ZERO) ? press_time : PRESS_DEF;
    assign evac_len  = (evac_time  != CNT_ZERO) ? evac_time  : EVAC_DEF;

    // Request pointing away from the current transition's target.
    assign opposite_req  = (state == ST_PRESSURIZING) ? evacuate_req : pressurize_req;
    assign target_state  = (state == ST_PRESSURIZING) ? ST_PRESSURIZED : ST_EVACUATED;
    assign reverse_state = (state == ST_PRESSURIZING) ? ST_EVACUATING : ST_PRESSURIZING;

    // Reversal length is the portion of the transition already covered.
    // A reversal on the very first busy cycle (cnt == len) would give zero,
    // which the counter cannot represent as an active transition, so it is
    // held at one cycle.
    assign elapsed     = len - cnt;
    assign reverse_len = (elapsed == CNT_ZERO) ? CNT_ONE : elapsed;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EVACUATED;
            cnt    <= CNT_ZERO;
            len    <= CNT_ZERO;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            len    <= len_next;
            done_q <= done_next;
            err_q  <= err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        len_next   = len;
        done_next  = 1'b0;
        err_next   = 1'b0;

        unique case (state)
            ST_EVACUATED: begin
                if (both_req) begin
                    err_next = 1'b1;
                end else if (pressurize_req) begin
                    state_next = ST_PRESSURIZING;
                    cnt_next   = press_len;
                    len_next   = press_len;
                end
            end

            ST_PRESSURIZED: begin
                if (both_req) begin
                    err_next = 1'b1;
                end else if (evacuate_req) begin
                    state_next = ST_EVACUATING;
                    cnt_next   = evac_len;
                    len_next   = evac_len;
                end
            end

            default: begin
                if (REV_EN && opposite_req && !both_req) begin
                    state_next = reverse_state;
                    cnt_next   = reverse_len;
                    len_next   = reverse_len;
                end else begin
                    // A rejected request (both high, or opposite with
                    // reversal disabled) flags err but never stalls the
                    // count. err wins over done if both land together.
                    err_next = opposite_req;
                    if (cnt == CNT_ONE) begin
                        state_next = target_state;
                        cnt_next   = CNT_ZERO;
                        done_next  = !opposite_req;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state and counter only)
    // -----------------------------------------------------------------------
    always_comb begin
        evacuated   = (state == ST_EVACUATED);
        pressurized = (state == ST_PRESSURIZED);
        busy        = (state == ST_PRESSURIZING) || (state == ST_EVACUATING);
        remaining   = cnt;
        done        = done_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_chamber_ctrl.sv
module tb_chamber_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       preq = 1'b0;
    logic       ereq = 1'b0;
    logic [7:0] pt = 8'd0;
    logic [7:0] et = 8'd0;

    logic       press0, evac0, busy0, done0, err0;
    logic [7:0] rem0;
    logic       press1, evac1, busy1, done1, err1;
    logic [7:0] rem1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = reversal allowed, 1 = reversal disabled
    int m_busy [2];
    int m_tgt  [2];   // 1: heading to pressurized, 0: heading to evacuated
    int m_side [2];   // stable side when idle: 1 pressurized, 0 evacuated
    int m_rem  [2];
    int m_len  [2];
    int m_done [2];
    int m_err  [2];

    always #5 clk = ~clk;

    chamber_ctrl #(.CNT_W(8), .PRESS_CYCLES(6), .EVAC_CYCLES(6), .ALLOW_REVERSE(1)) dut_rev (
        .clk(clk), .rst(rst), .pressurize_req(preq), .evacuate_req(ereq),
        .press_time(pt), .evac_time(et),
        .pressurized(press0), .evacuated(evac0), .busy(busy0),
        .remaining(rem0), .done(done0), .err(err0)
    );

    chamber_ctrl #(.CNT_W(8), .PRESS_CYCLES(6), .EVAC_CYCLES(6), .ALLOW_REVERSE(0)) dut_norev (
        .clk(clk), .rst(rst), .pressurize_req(preq), .evacuate_req(ereq),
        .press_time(pt), .evac_time(et),
        .pressurized(press1), .evacuated(evac1), .busy(busy1),
        .remaining(rem1), .done(done1), .err(err1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_tgt[i] = 0; m_side[i] = 0;
            m_rem[i]  = 0; m_len[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
    endfunction

    // One clock edge of chamber behaviour, described in terms of
    // "where is it heading, how long is left".
    function automatic void model_step(input int i, input bit p, input bit e);
        bit rev;
        bit opp;
        int el;
        rev = (i == 0);
        m_done[i] = 0;
        m_err[i]  = 0;
        if (m_busy[i] != 0) begin
            opp = (m_tgt[i] == 1) ? e : p;
            if (opp && !(p && e) && rev) begin
                el = m_len[i] - m_rem[i];
                if (el < 1) el = 1;
                m_tgt[i] = 1 - m_tgt[i];
                m_rem[i] = el;
                m_len[i] = el;
            end else begin
                m_err[i] = opp;
                if (m_rem[i] == 1) begin
                    m_busy[i] = 0;
                    m_side[i] = m_tgt[i];
                    m_rem[i]  = 0;
                    m_done[i] = !opp;
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end
        end else if (p && e) begin
            m_err[i] = 1;
        end else if (m_side[i] == 0 && p) begin
            m_busy[i] = 1; m_tgt[i] = 1;
            m_len[i]  = (pt == 0) ? 6 : int'(pt);
            m_rem[i]  = m_len[i];
        end else if (m_side[i] == 1 && e) begin
            m_busy[i] = 1; m_tgt[i] = 0;
            m_len[i]  = (et == 0) ? 6 : int'(et);
            m_rem[i]  = m_len[i];
        end
    endfunction

    task automatic chk_inst(input string nm, input int i,
                            input logic ev, input logic pr, input logic bs,
                            input logic [7:0] rm, input logic dn, input logic er);
        chk({nm, ".evacuated"},   int'(ev), (m_busy[i] == 0 && m_side[i] == 0) ? 1 : 0);
        chk({nm, ".pressurized"}, int'(pr), (m_busy[i] == 0 && m_side[i] == 1) ? 1 : 0);
        chk({nm, ".busy"},        int'(bs), m_busy[i]);
        chk({nm, ".remaining"},   int'(rm), m_rem[i]);
        chk({nm, ".done"},        int'(dn), m_done[i]);
        chk({nm, ".err"},         int'(er), m_err[i]);
        chk({nm, ".done_and_err"}, int'(dn & er), 0);
    endtask

    task automatic check_all();
        chk_inst("rev",   0, evac0, press0, busy0, rem0, done0, err0);
        chk_inst("norev", 1, evac1, press1, busy1, rem1, done1, err1);
    endtask

    task automatic cycle(input bit p, input bit e);
        preq = p;
        ereq = e;
        @(posedge clk);
        model_step(0, p, e);
        model_step(1, p, e);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        // Reset state, before any clock edge
        model_reset();
        #1;
        check_all();
        #2;
        rst = 1'b1;

        // Default pressurize duration
        pt = 8'd0; et = 8'd0;
        cycle(1'b1, 1'b0);
        chk("t_def.rem_start", int'(rem0), 6);
        idle(5);
        chk("t_def.rem_last", int'(rem0), 1);
        idle(1);
        chk("t_def.pressurized", int'(press0), 1);
        chk("t_def.done", int'(done0), 1);
        idle(1);
        chk("t_def.done_low", int'(done0), 0);

        // Back to evacuated on default time, then programmed durations
        cycle(1'b0, 1'b1);
        idle(6);
        chk("t_evdef.evacuated", int'(evac0), 1);
        pt = 8'd10; et = 8'd3;
        cycle(1'b1, 1'b0);
        chk("t_prog.rem_start", int'(rem0), 10);
        idle(3);
        pt = 8'd2;
        idle(6);
        chk("t_prog.still_busy", int'(busy0), 1);
        idle(1);
        chk("t_prog.pressurized", int'(press0), 1);
        cycle(1'b0, 1'b1);
        chk("t_prog.evac_rem", int'(rem0), 3);
        idle(3);
        chk("t_prog.evacuated", int'(evac0), 1);

        // Mid-transition reversal versus rejection
        pt = 8'd8;
        cycle(1'b1, 1'b0);
        idle(3);
        chk("t_rev.rem_before", int'(rem0), 5);
        cycle(1'b0, 1'b1);
        chk("t_rev.rem_after", int'(rem0), 3);
        chk("t_rev.err", int'(err0), 0);
        chk("t_norev.err", int'(err1), 1);
        chk("t_norev.rem", int'(rem1), 4);
        idle(3);
        chk("t_rev.evacuated", int'(evac0), 1);
        chk("t_rev.done", int'(done0), 1);
        idle(1);
        chk("t_norev.pressurized", int'(press1), 1);
        cycle(1'b0, 1'b1);
        idle(4);

        // Conflicting and idempotent requests in EVACUATED
        cycle(1'b1, 1'b1);
        chk("t_both.err", int'(err0), 1);
        chk("t_both.evacuated", int'(evac0), 1);
        cycle(1'b0, 1'b1);
        chk("t_idem.err", int'(err0), 0);
        chk("t_idem.evacuated", int'(evac0), 1);

        // Asynchronous reset in the middle of pressurizing
        pt = 8'd5;
        cycle(1'b1, 1'b0);
        idle(2);
        chk("t_rst.rem_before", int'(rem0), 3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t_rst.evacuated", int'(evac0), 1);
        chk("t_rst.busy", int'(busy0), 0);
        chk("t_rst.remaining", int'(rem0), 0);
        chk("t_rst.done", int'(done0), 0);
        check_all();
        #2;
        rst = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 7) == 0) pt = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) et = 8'($urandom_range(0, 12));
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
